ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the byte address of the first fetch after reset.
REQ-002 clk  input  1  the single rising-edge clock.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 oimem_req  output  1  instruction-memory read request this cycle.
REQ-005 oimem_addr  output  32  byte address of the request, bits [1:0] always 0.
REQ-006 iimem_data  input  32  read data; valid exactly 1 cycle after its request.
REQ-007 iBranchTaken  input  1  redirect strobe from the downstream pipeline.
REQ-008 iBranchTarget  input  32  redirect byte address.
REQ-009 iStall  input  1  the decode stage is not accepting this cycle.
REQ-010 ovalid  output  1  oins/o_temp_npc hold a valid instruction.
REQ-011 oins  output  32  instruction presented to decode.
REQ-012 o_temp_npc  output  32  address of that instruction + 4.

Function
REQ-013 Internal state SHALL be: pc register, 2-entry FIFO of {ins, npc}, in-flight flag with its npc, and count 0..2.
REQ-014 Outputs SHALL show the FIFO head; when count=0, ovalid=0 and oins=o_temp_npc=0.
REQ-015 A pop SHALL occur when ovalid=1, iStall=0 and iBranchTaken=0.
REQ-016 Occupancy occ = count + inflight - pop; a request SHALL issue (oimem_req=1, oimem_addr=pc) iff occ<2 and iBranchTaken=0.
REQ-017 On an issued request, pc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), and the in-flight flag SHALL set with npc=pc+4.
REQ-018 A valid response SHALL be written to the FIFO tail at the end of its cycle, so it is visible the next cycle; push and pop in the same cycle SHALL leave count unchanged.
REQ-019 Issue timing: the first request issues in the first cycle after reset release; the first ovalid follows 2 cycles later. With iStall=0 the block SHALL sustain 1 instruction per cycle.
REQ-020 iStall=1 SHALL hold the head stable; fetching SHALL continue until occ=2, then stop with no lost or duplicated instruction.
REQ-021 iBranchTaken=1 SHALL have priority over iStall, pop and request. In the same cycle: no request, FIFO cleared (count=0), in-flight response discarded, pc <= {iBranchTarget[31:2],2'b00}.
REQ-022 After a redirect, the first request SHALL be to the target in the next cycle, and ovalid SHALL stay 0 until that response is written.
REQ-023 Back-to-back redirects: the last one SHALL win, and no response from an earlier address SHALL reach the FIFO.
REQ-024 FIFO overflow and underflow SHALL be impossible by construction; a sim-only assertion SHALL flag count>2 or a push when full.

Reset
REQ-025 While rstn=0, asynchronously: pc=RESET_PC, count=0, in-flight=0, oimem_req=0, ovalid=0, oins=0, o_temp_npc=0.
REQ-026 A reset mid-operation SHALL discard all buffered and in-flight instructions; a response arriving in the first cycle after reset release SHALL be ignored.

Verification
REQ-027 Reset release, memory M[a]=a+32'h100, iStall=0: req addr 0,4,8 in cycles 0,1,2; ovalid=1 from cycle 2; oins=100,104,108; o_temp_npc=4,8,C.
REQ-028 iStall=1 for 5 cycles during streaming: oins held; oimem_req stops after occ=2; on release the sequence continues with no gap or duplicate.
REQ-029 iBranchTaken=1 with target 32'h0000_0043 while 2 entries are buffered and 1 is in flight: ovalid=0 next cycle; next request addr 32'h40; then oins=M[40], o_temp_npc=32'h44.
REQ-030 Redirect to 32'h200 then 32'h300 in consecutive cycles: only addresses 300, 304, ... reach oins.
REQ-031 RESET_PC=32'hFFFF_FFF8, no stall: request addresses FFFF_FFF8, FFFF_FFFC, 0; o_temp_npc=FFFF_FFFC, 0, 4.
REQ-032 rstn pulsed low mid-stream with a request in flight: outputs are 0 immediately; after release fetch restarts at RESET_PC and no pre-reset data appears.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch front end: sequential PC, one-cycle-latency memory, two-entry
// instruction buffer toward decode, with redirect flush.
module ins_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        oimem_req,
    output logic [31:0] oimem_addr,
    input  logic [31:0] iimem_data,
    input  logic        iBranchTaken,
    input  logic [31:0] iBranchTarget,
    input  logic        iStall,
    output logic        ovalid,
    output logic [31:0] oins,
    output logic [31:0] o_temp_npc
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] fifoIns [2];
    logic [31:0] fifoNpc [2];
    logic        headPtr;
    logic        tailPtr;
    logic [1:0]  count;
    logic        inflight;
    logic [31:0] inflightNpc;

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  occ;

    always_comb begin
        ovalid     = (count != 2'd0);
        oins       = ovalid ? fifoIns[headPtr] : '0;
        o_temp_npc = ovalid ? fifoNpc[headPtr] : '0;

        pop     = ovalid && !iStall && !iBranchTaken;
        push    = inflight && !iBranchTaken;
        tailPtr = headPtr ^ count[0];

        // Entries already owned (buffered + in flight) after this cycle's pop.
        occ   = count + {1'b0, inflight} - {1'b0, pop};
        issue = !iBranchTaken && (occ < 2'd2);

        // Gated by rstn so the request is held low throughout reset.
        oimem_req  = issue && rstn;
        oimem_addr = pc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= RESET_PC_ALIGNED;
            count       <= '0;
            headPtr     <= 1'b0;
            inflight    <= 1'b0;
            inflightNpc <= '0;
        end else if (iBranchTaken) begin
            pc       <= {iBranchTarget[31:2], 2'b00};
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 32'd4;
                inflightNpc <= pc + 32'd4;
            end
            if (pop) begin
                headPtr <= ~headPtr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoIns[tailPtr] <= iimem_data;
            fifoNpc[tailPtr] <= inflightNpc;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rstn) count != 2'd3)
        else $error("ins_fetch: buffer count exceeded 2");
    assert property (@(posedge clk) disable iff (!rstn) !(push && !pop && count == 2'd2))
        else $error("ins_fetch: push into full buffer");
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus randomized stall/redirect
// traffic compared against a queue-based model of the fetch stream.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        oimem_req, req2;
    logic [31:0] oimem_addr, addr2;
    logic [31:0] iimem_data, data2;
    logic        iBranchTaken;
    logic [31:0] iBranchTarget;
    logic        iStall;
    logic        ovalid, valid2;
    logic [31:0] oins, ins2;
    logic [31:0] o_temp_npc, npc2;

    always #5 clk = ~clk;

    ins_fetch dut (
        .clk(clk), .rstn(rstn), .oimem_req(oimem_req), .oimem_addr(oimem_addr),
        .iimem_data(iimem_data), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iStall(iStall), .ovalid(ovalid), .oins(oins), .o_temp_npc(o_temp_npc)
    );

    ins_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rstn(rstn), .oimem_req(req2), .oimem_addr(addr2),
        .iimem_data(data2), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iStall(iStall), .ovalid(valid2), .oins(ins2), .o_temp_npc(npc2)
    );

    int checks = 0;
    int errors = 0;

    // Model: addresses requested since the last flush and not yet consumed, with issue cycle.
    logic [31:0] pendAddr [$];
    int          pendCyc  [$];
    logic [31:0] nextAddr;
    int          cyc;

    logic        expReq, expValid;
    logic [31:0] expAddr, expIns, expNpc;
    logic        sReq, sValid, s2Req, s2Valid;
    logic [31:0] sAddr, sIns, sNpc, s2Addr, s2Npc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic model_reset();
        pendAddr.delete();
        pendCyc.delete();
        nextAddr = 32'h0;
        cyc      = 0;
    endtask

    // One clock cycle: drive inputs, predict, sample mid-cycle, clock, then update model/memory.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt);
        logic mPop;
        iStall        = st;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        expValid = (pendAddr.size() > 0) && (cyc >= pendCyc[0] + 2);
        expIns   = expValid ? memf(pendAddr[0]) : 32'h0;
        expNpc   = expValid ? pendAddr[0] + 32'd4 : 32'h0;
        mPop     = expValid && !st && !br;
        expReq   = !br && ((pendAddr.size() - (mPop ? 1 : 0)) < 2);
        expAddr  = nextAddr;
        #4;
        sReq = oimem_req; sAddr = oimem_addr; sValid = ovalid; sIns = oins; sNpc = o_temp_npc;
        s2Req = req2; s2Addr = addr2; s2Valid = valid2; s2Npc = npc2;
        @(posedge clk);
        #1;
        if (br) begin
            pendAddr.delete();
            pendCyc.delete();
            nextAddr = {tgt[31:2], 2'b00};
        end else begin
            if (mPop) begin
                void'(pendAddr.pop_front());
                void'(pendCyc.pop_front());
            end
            if (expReq) begin
                pendAddr.push_back(nextAddr);
                pendCyc.push_back(cyc);
                nextAddr = nextAddr + 32'd4;
            end
        end
        cyc = cyc + 1;
        iimem_data = sReq  ? memf(sAddr)  : $urandom();
        data2      = s2Req ? memf(s2Addr) : $urandom();
    endtask

    task automatic release_reset(input logic [31:0] stale);
        repeat (2) @(posedge clk);
        #1;
        rstn       = 1'b1;
        iimem_data = stale;
        data2      = stale;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (oimem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", oimem_req); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ovalid); end
        checks++; if (oins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h expected 0", oins); end
        checks++; if (o_temp_npc !== 32'h0) begin errors++; $display("FAIL reset_npc: got %h expected 0", o_temp_npc); end
        checks++; if (oimem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", oimem_addr); end
        release_reset(32'hDEAD_BEEF);
    endtask

    task automatic test_stream();
        logic [31:0] a2;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0);
            checks++; if (sReq !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %b expected 1", i, sReq); end
            checks++; if (sAddr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, sAddr, 32'(4 * i)); end
            checks++; if (sValid !== (i >= 2)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, sValid, i >= 2); end
            if (i >= 2) begin
                checks++; if (sIns !== 32'h100 + 32'(4 * (i - 2))) begin errors++; $display("FAIL stream_ins[%0d]: got %h expected %h", i, sIns, 32'h100 + 32'(4 * (i - 2))); end
                checks++; if (sNpc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_npc[%0d]: got %h expected %h", i, sNpc, 32'(4 * (i - 1))); end
            end
            if (i < 3) begin
                a2 = 32'hFFFF_FFF8 + 32'(4 * i);
                checks++; if (s2Addr !== a2 || s2Req !== 1'b1) begin errors++; $display("FAIL wrap_addr[%0d]: got %h req %b expected %h", i, s2Addr, s2Req, a2); end
            end
            if (i >= 2 && i < 5) begin
                a2 = 32'hFFFF_FFFC + 32'(4 * (i - 2));
                checks++; if (s2Npc !== a2 || s2Valid !== 1'b1) begin errors++; $display("FAIL wrap_npc[%0d]: got %h valid %b expected %h", i, s2Npc, s2Valid, a2); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (i == 0) held = sIns;
            checks++; if (sValid !== 1'b1 || sIns !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %h valid %b expected %h", i, sIns, sValid, held); end
            checks++; if (sReq !== expReq) begin errors++; $display("FAIL stall_req[%0d]: got %b expected %b", i, sReq, expReq); end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                checks++; if (sIns !== held) begin errors++; $display("FAIL stall_resume: got %h expected %h", sIns, held); end
            end
            checks++; if (sValid !== 1'b1) begin errors++; $display("FAIL stall_gap[%0d]: got %b expected 1", i, sValid); end
            checks++; if (sIns !== expIns || sNpc !== expNpc) begin errors++; $display("FAIL stall_seq[%0d]: got %h/%h expected %h/%h", i, sIns, sNpc, expIns, expNpc); end
        end
    endtask

    task automatic test_branch();
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0043);
        checks++; if (sReq !== 1'b0) begin errors++; $display("FAIL branch_noreq: got %b expected 0", sReq); end
        step(1'b0, 1'b0, 32'h0);
        checks++; if (sValid !== 1'b0) begin errors++; $display("FAIL branch_flush: got %b expected 0", sValid); end
        checks++; if (sReq !== 1'b1 || sAddr !== 32'h40) begin errors++; $display("FAIL branch_target: got %h req %b expected 00000040", sAddr, sReq); end
        step(1'b0, 1'b0, 32'h0);
        checks++; if (sValid !== 1'b0) begin errors++; $display("FAIL branch_wait: got %b expected 0", sValid); end
        step(1'b0, 1'b0, 32'h0);
        checks++; if (sValid !== 1'b1 || sIns !== 32'h140 || sNpc !== 32'h44) begin errors++; $display("FAIL branch_first: got %b %h/%h expected 1 00000140/00000044", sValid, sIns, sNpc); end
    endtask

    task automatic test_back_to_back();
        repeat (2) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 32'h0000_0300);
        checks++; if (sReq !== 1'b0) begin errors++; $display("FAIL b2b_noreq: got %b expected 0", sReq); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                checks++; if (sAddr !== 32'h300 || sReq !== 1'b1) begin errors++; $display("FAIL b2b_addr: got %h expected 00000300", sAddr); end
            end
            if (i == 2) begin
                checks++; if (sValid !== 1'b1 || sIns !== 32'h400) begin errors++; $display("FAIL b2b_first: got %b %h expected 1 00000400", sValid, sIns); end
            end
            checks++; if (sValid !== expValid || sIns !== expIns || sNpc !== expNpc) begin errors++; $display("FAIL b2b_seq[%0d]: got %b %h/%h expected %b %h/%h", i, sValid, sIns, sNpc, expValid, expIns, expNpc); end
        end
    endtask

    task automatic test_reset_midstream();
        repeat (3) step(1'b0, 1'b0, 32'h0);
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (oimem_req !== 1'b0 || ovalid !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got req %b valid %b expected 0 0", oimem_req, ovalid); end
        checks++; if (oins !== 32'h0 || o_temp_npc !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h/%h expected 0/0", oins, o_temp_npc); end
        checks++; if (valid2 !== 1'b0 || req2 !== 1'b0) begin errors++; $display("FAIL midreset_dut2: got valid %b req %b expected 0 0", valid2, req2); end
        release_reset(memf(32'h0000_0008));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                checks++; if (sReq !== 1'b1 || sAddr !== 32'h0) begin errors++; $display("FAIL midreset_restart: got %h req %b expected 00000000", sAddr, sReq); end
            end
            checks++; if (sValid !== (i >= 2)) begin errors++; $display("FAIL midreset_valid[%0d]: got %b expected %b", i, sValid, i >= 2); end
            if (i >= 2) begin
                checks++; if (sIns !== 32'h100 + 32'(4 * (i - 2)) || sNpc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL midreset_ins[%0d]: got %h/%h expected %h/%h", i, sIns, sNpc, 32'h100 + 32'(4 * (i - 2)), 32'(4 * (i - 1))); end
            end
        end
    endtask

    task automatic test_random();
        logic        st, br;
        logic [31:0] tgt;
        for (int i = 0; i < 500; i++) begin
            st  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            step(st, br, tgt);
            checks++; if (sReq !== expReq) begin errors++; $display("FAIL rand_req[%0d]: got %b expected %b", i, sReq, expReq); end
            if (expReq) begin
                checks++; if (sAddr !== expAddr) begin errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, sAddr, expAddr); end
            end
            checks++; if (sValid !== expValid) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, sValid, expValid); end
            checks++; if (sIns !== expIns) begin errors++; $display("FAIL rand_ins[%0d]: got %h expected %h", i, sIns, expIns); end
            checks++; if (sNpc !== expNpc) begin errors++; $display("FAIL rand_npc[%0d]: got %h expected %h", i, sNpc, expNpc); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn          = 1'b0;
        iStall        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 32'h0;
        iimem_data    = 32'h0;
        data2         = 32'h0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
